// File: rtl/cache_axi_bridge_if.sv
// AXI3/4 master-side bus carried by cache_axi_bridge.
// Groups the AR, R, AW, W and B channels. Fixed AXI fields (ids, burst,
// lock, cache, prot) and the rresp/bresp codes are handled at top level,
// so they do not appear here.
//   master : bridge side (drives AR/AW/W payloads and valids, rready, bready)
//   slave  : interconnect side
interface cache_axi_bridge_if;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic        arvalid;
    logic        arready;

    logic [31:0] rdata;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic        awvalid;
    logic        awready;

    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;

    logic        bvalid;
    logic        bready;

    modport master (
        output araddr, arlen, arsize, arvalid,
        input  arready,
        input  rdata, rlast, rvalid,
        output rready,
        output awaddr, awlen, awsize, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bvalid,
        output bready
    );

    modport slave (
        input  araddr, arlen, arsize, arvalid,
        output arready,
        output rdata, rlast, rvalid,
        input  rready,
        input  awaddr, awlen, awsize, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bvalid,
        input  bready
    );
endinterface

// File: rtl/cache_axi_bridge.sv
// Responder for the cache miss interface. Each accepted cache request becomes
// one AXI transaction; read beats are forwarded straight back to the cache,
// writes complete on the B response. One read and one write may be in flight.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   rd_req/rd_type/rd_addr, rd_rdy       cache read request and accept
//   ret_valid/ret_last/ret_data          read return beats to the cache
//   wr_req/wr_type/wr_addr/wr_wstrb/wr_data, wr_rdy  cache write request
//   axi                 AXI master channels (cache_axi_bridge_if.master)
// Type encoding: 000 byte, 001 half, 010 word, 100 line.
module cache_axi_bridge #(
    parameter int LINE_WORDS = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    rd_req,
    input  logic [2:0]              rd_type,
    input  logic [31:0]             rd_addr,
    output logic                    rd_rdy,
    output logic                    ret_valid,
    output logic                    ret_last,
    output logic [31:0]             ret_data,
    input  logic                    wr_req,
    input  logic [2:0]              wr_type,
    input  logic [31:0]             wr_addr,
    input  logic [3:0]              wr_wstrb,
    input  logic [32*LINE_WORDS-1:0] wr_data,
    output logic                    wr_rdy,
    cache_axi_bridge_if.master      axi
);
    localparam int CW = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;

    typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_AW, W_DATA, W_RESP} w_state_t;

    function automatic logic [7:0] len_of(input logic [2:0] t);
        return (t == 3'b100) ? 8'(LINE_WORDS - 1) : 8'd0;
    endfunction

    function automatic logic [2:0] size_of(input logic [2:0] t);
        case (t)
            3'b000:  return 3'd0;
            3'b001:  return 3'd1;
            default: return 3'd2;
        endcase
    endfunction

    r_state_t r_state;
    w_state_t w_state;

    logic [31:0]             ar_addr_q, aw_addr_q;
    logic [7:0]              ar_len_q, aw_len_q;
    logic [2:0]              ar_size_q, aw_size_q;
    logic [3:0]              w_strb_q;
    logic [32*LINE_WORDS-1:0] w_data_q;
    logic [CW-1:0]           w_cnt;
    logic                    ar_valid_q, r_ready_q;
    logic                    aw_valid_q, w_valid_q, b_ready_q;
    logic                    w_last;

    // Reads wait for the write side to drain so a refill never passes a
    // pending writeback to the same line.
    assign rd_rdy = !reset && (r_state == R_IDLE) && (w_state == W_IDLE);
    assign wr_rdy = !reset && (w_state == W_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= R_IDLE;
            ar_valid_q <= 1'b0;
            r_ready_q  <= 1'b0;
            ar_addr_q  <= '0;
            ar_len_q   <= '0;
            ar_size_q  <= '0;
        end else begin
            case (r_state)
                R_IDLE: if (rd_req && (w_state == W_IDLE)) begin
                    ar_addr_q  <= rd_addr;
                    ar_len_q   <= len_of(rd_type);
                    ar_size_q  <= size_of(rd_type);
                    ar_valid_q <= 1'b1;
                    r_state    <= R_AR;
                end
                R_AR: if (axi.arready) begin
                    ar_valid_q <= 1'b0;
                    r_ready_q  <= 1'b1;
                    r_state    <= R_DATA;
                end
                R_DATA: if (axi.rvalid && axi.rlast) begin
                    r_ready_q <= 1'b0;
                    r_state   <= R_IDLE;
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    assign w_last = (w_cnt == aw_len_q[CW-1:0]);

    always_ff @(posedge clk) begin
        if (reset) begin
            w_state    <= W_IDLE;
            aw_valid_q <= 1'b0;
            w_valid_q  <= 1'b0;
            b_ready_q  <= 1'b0;
            w_cnt      <= '0;
            aw_addr_q  <= '0;
            aw_len_q   <= '0;
            aw_size_q  <= '0;
            w_strb_q   <= '0;
            w_data_q   <= '0;
        end else begin
            case (w_state)
                W_IDLE: if (wr_req) begin
                    aw_addr_q  <= wr_addr;
                    aw_len_q   <= len_of(wr_type);
                    aw_size_q  <= size_of(wr_type);
                    w_strb_q   <= (wr_type == 3'b100) ? 4'hf : wr_wstrb;
                    w_data_q   <= wr_data;
                    aw_valid_q <= 1'b1;
                    w_state    <= W_AW;
                end
                W_AW: if (axi.awready) begin
                    aw_valid_q <= 1'b0;
                    w_valid_q  <= 1'b1;
                    w_cnt      <= '0;
                    w_state    <= W_DATA;
                end
                W_DATA: if (axi.wready) begin
                    w_cnt <= w_cnt + 1'b1;
                    if (w_last) begin
                        w_valid_q <= 1'b0;
                        b_ready_q <= 1'b1;
                        w_state   <= W_RESP;
                    end
                end
                W_RESP: if (axi.bvalid) begin
                    b_ready_q <= 1'b0;
                    w_state   <= W_IDLE;
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Handshake flags are registered alongside the state; masking with reset
    // keeps them low during the reset cycle itself, before the flops clear.
    assign axi.arvalid = ar_valid_q && !reset;
    assign axi.rready  = r_ready_q  && !reset;
    assign axi.awvalid = aw_valid_q && !reset;
    assign axi.wvalid  = w_valid_q  && !reset;
    assign axi.bready  = b_ready_q  && !reset;

    assign axi.araddr = ar_addr_q;
    assign axi.arlen  = ar_len_q;
    assign axi.arsize = ar_size_q;
    assign axi.awaddr = aw_addr_q;
    assign axi.awlen  = aw_len_q;
    assign axi.awsize = aw_size_q;
    assign axi.wdata  = w_data_q[32*w_cnt +: 32];
    assign axi.wstrb  = w_strb_q;
    assign axi.wlast  = w_last;

    assign ret_valid = axi.rvalid && axi.rready;
    assign ret_last  = ret_valid && axi.rlast;
    assign ret_data  = axi.rdata;
endmodule
